// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the execute-stage comparators, the branch
// resolve unit and the fetch redirect path.
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    // Valid/ready: a transfer happens on a rising clock edge where valid and
    // ready are both high; once valid is raised, the payload stays stable
    // until that edge, and ready may depend combinationally on the far side.
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      funct3_i;
    logic [PC_W-1:0] pc_i;
    logic [PC_W-1:0] imm_i;
    logic            pred_taken_i;
    logic            s_equal_i;
    logic            s_alarger_i;
    logic            s_blarger_i;
    logic            u_equal_i;
    logic            u_alarger_i;
    logic            u_blarger_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            taken_o;
    logic [PC_W-1:0] target_o;
    logic            illegal_o;
    logic            redirect_o;
    logic [PC_W-1:0] redirect_pc_o;

    modport master (
        output in_valid_i, funct3_i, pc_i, imm_i, pred_taken_i,
        output s_equal_i, s_alarger_i, s_blarger_i,
        output u_equal_i, u_alarger_i, u_blarger_i,
        output flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, taken_o, target_o, illegal_o,
        input  redirect_o, redirect_pc_o
    );

    modport slave (
        input  in_valid_i, funct3_i, pc_i, imm_i, pred_taken_i,
        input  s_equal_i, s_alarger_i, s_blarger_i,
        input  u_equal_i, u_alarger_i, u_blarger_i,
        input  flush_i, out_ready_i,
        output in_ready_o, out_valid_o, taken_o, target_o, illegal_o,
        output redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches from comparator flag triples and drives
// the fetch redirect. Define BRANCH_RESOLVE_STATS_EN for branch/mispredict counters.
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    branch_resolve_unit_if.slave bus,
    output logic [1:0]           dbg_state
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [CNT_W-1:0]     br_count_o,
    output logic [CNT_W-1:0]     mispredict_count_o
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FULL   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t          state;
    logic            taken_q;
    logic            illegal_q;
    logic            mispredict_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] redirect_pc_q;

    logic            s_onehot;
    logic            u_onehot;
    logic            legal_f3;
    logic            cond;
    logic            req_illegal;
    logic            req_taken;
    logic            req_mispredict;
    logic [PC_W-1:0] req_target;
    logic [PC_W-1:0] req_fallthrough;
    logic [PC_W-1:0] req_redirect_pc;
    logic            in_ready;
    logic            accept;
    logic            out_hs;
    logic            redirect;

    always_comb begin
        s_onehot = 1'b0;
        u_onehot = 1'b0;
        case ({bus.s_equal_i, bus.s_alarger_i, bus.s_blarger_i})
            3'b100, 3'b010, 3'b001: s_onehot = 1'b1;
            default:                s_onehot = 1'b0;
        endcase
        case ({bus.u_equal_i, bus.u_alarger_i, bus.u_blarger_i})
            3'b100, 3'b010, 3'b001: u_onehot = 1'b1;
            default:                u_onehot = 1'b0;
        endcase
    end

    // funct3 01x has no branch encoding; everything else maps to one flag.
    always_comb begin
        legal_f3 = 1'b1;
        cond     = 1'b0;
        case (bus.funct3_i)
            3'b000:  cond = bus.s_equal_i;
            3'b001:  cond = ~bus.s_equal_i;
            3'b100:  cond = bus.s_blarger_i;
            3'b101:  cond = ~bus.s_blarger_i;
            3'b110:  cond = bus.u_blarger_i;
            3'b111:  cond = ~bus.u_blarger_i;
            default: legal_f3 = 1'b0;
        endcase
    end

    assign req_illegal     = ~legal_f3 | ~s_onehot | ~u_onehot;
    assign req_taken       = ~req_illegal & cond;
    assign req_target      = bus.pc_i + bus.imm_i;
    assign req_fallthrough = bus.pc_i + PC_W'(4);
    assign req_redirect_pc = req_taken ? req_target : req_fallthrough;
    assign req_mispredict  = ~req_illegal & (req_taken != bus.pred_taken_i);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = ~bus.flush_i;
            FULL:    in_ready = bus.out_ready_i & ~bus.flush_i & ~mispredict_q;
            SQUASH:  in_ready = ~bus.flush_i;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept   = bus.in_valid_i & in_ready;
    assign out_hs   = (state == FULL) & bus.out_ready_i & ~bus.flush_i;
    assign redirect = out_hs & mispredict_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            taken_q       <= 1'b0;
            illegal_q     <= 1'b0;
            mispredict_q  <= 1'b0;
            target_q      <= '0;
            redirect_pc_q <= '0;
        end else if (bus.flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= FULL;
                        taken_q       <= req_taken;
                        illegal_q     <= req_illegal;
                        mispredict_q  <= req_mispredict;
                        target_q      <= req_target;
                        redirect_pc_q <= req_redirect_pc;
                    end
                end
                FULL: begin
                    if (bus.out_ready_i) begin
                        if (mispredict_q) begin
                            state <= SQUASH;
                        end else if (accept) begin
                            taken_q       <= req_taken;
                            illegal_q     <= req_illegal;
                            mispredict_q  <= req_mispredict;
                            target_q      <= req_target;
                            redirect_pc_q <= req_redirect_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                // Wrong-path requests are accepted and dropped until flush.
                SQUASH:  state <= SQUASH;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = (state == FULL);
    assign bus.taken_o       = taken_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.target_o      = target_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.redirect_o    = redirect;
    assign dbg_state         = state;

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_count_o         <= '0;
            mispredict_count_o <= '0;
        end else begin
            if (out_hs && (br_count_o != '1))
                br_count_o <= br_count_o + CNT_W'(1);
            if (redirect && (mispredict_count_o != '1))
                mispredict_count_o <= mispredict_count_o + CNT_W'(1);
        end
    end
`endif
endmodule
